wb_initiator: RTL and testbench
===============================

Name: wb_initiator

Overview:
Wishbone classic single-transfer initiator. It converts a simple valid/ready request/response port (CPU load/store unit or debug loader) into Wishbone cycles. It drives the bus that the SoC RAM responder and peripherals terminate. At most one transaction is outstanding. A timeout counter converts a missing ack into an error response, so a dead slave cannot hang the core.

Parameters:
TIMEOUT, 255, number of clock edges with stb high without ack before the cycle is aborted with error (must be >= 1)
CNT_W, $clog2(TIMEOUT+1), width of the timeout counter (derived, do not override)

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at posedge clk
req_addr  in  32  byte address
req_wdata  in  32  write data
req_sel  in  4  byte enables
req_we  in  1  1 = write, 0 = read
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at posedge clk
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  1 = timeout abort
wb_addr  out  32  Wishbone address, {req_addr[31:2],2'b00}
wb_wdata  out  32  Wishbone write data
wb_sel  out  4  Wishbone byte select
wb_we  out  1  Wishbone write enable
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe (always equal to wb_cyc)
wb_rdata  in  32  Wishbone read data
wb_ack  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0 except req_ready = 1; counter 0; all wb_* outputs 0.
- Reset mid-transaction drops wb_cyc/wb_stb immediately. Any pending response is discarded.
- State IDLE: req_ready = 1, wb_cyc = wb_stb = 0. On req_valid at a posedge: register addr/wdata/sel/we onto the wb_* outputs, set cyc = stb = 1, clear counter, go to BUS.
- State BUS: req_ready = 0. Outputs are held stable; all bus outputs are registered, with no combinational path from req_* to wb_*.
  - At each posedge with wb_ack = 1: latch rsp_rdata = we ? 0 : wb_rdata, rsp_err = 0, drop cyc/stb, set rsp_valid, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 and ack is still 0 at that edge, abort: drop cyc/stb, rsp_err = 1, rsp_rdata = 0, rsp_valid = 1, go to RESP.
  - If ack arrives on the same edge that would time out, ack wins and the response is a normal one.
- State RESP: rsp_valid = 1 with rdata/err held stable. On rsp_ready: rsp_valid = 0, go to IDLE. No new request is accepted in RESP.
- wb_ack while in IDLE or RESP is ignored.
- Latency against a responder with ack registered 2 cycles after stb (SoC RAM):
  - acceptance edge E0, stb high after E0
  - ack sampled at E3, rsp_valid high after E3
  - with rsp_ready tied to 1, req_ready returns after E4
- cyc/stb drop in the cycle after ack is sampled. This is required so that registered-ack responders do not re-trigger.
- Data is passed through with no byte swapping; endianness is the responder's concern.

Decomposition:
- Shared package wb_pkg holds:
  - localparams WB_AW = 32, WB_DW = 32, WB_SELW = 4
  - state encoding enum wb_init_state_e {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2}, reused by future bus masters
- Single module; no sub-module. The timeout counter is too small to split out.

Test Plan:
- Read, responder acks 2 cycles after stb with wb_rdata = 32'hDEADBEEF; req_addr = 32'h0000_0104 -> wb_addr = 32'h104, wb_we = 0, rsp_valid after E3, rsp_rdata = 32'hDEADBEEF, rsp_err = 0.
- Write req_addr = 32'h0000_0203, sel = 4'b0011, wdata = 32'h1234_5678 -> wb_addr = 32'h200, wb_sel = 4'b0011, wb_we = 1, rsp_rdata = 0, cyc/stb low the cycle after ack.
- No ack, TIMEOUT = 8 -> stb high for exactly 8 cycles, then rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; an ack injected 2 cycles later is ignored.
- Ack on the exact timeout edge with wb_rdata = 32'hA5A5A5A5 -> rsp_err = 0, rsp_rdata = 32'hA5A5A5A5.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable; req_ready = 0 throughout; req_ready = 1 the cycle after the handshake.
- rst_n pulsed low while in BUS -> wb_cyc, wb_stb, rsp_valid = 0 asynchronously, req_ready = 1; the next request completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for Wishbone bus masters in this SoC.
//   WB_AW / WB_DW / WB_SELW : address, data and byte-select widths
//   wb_init_state_e         : single-transfer initiator state encoding
//   wb_word_addr()          : force a byte address onto a 32-bit word boundary
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_init_state_e;

  // Word-align a byte address; byte lanes are selected through wb_sel instead.
  function automatic logic [WB_AW-1:0] wb_word_addr(input logic [WB_AW-1:0] addr);
    return {addr[WB_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
// Wishbone classic single-transfer initiator. Converts a valid/ready request /
// response port into Wishbone cycles, with at most one transfer outstanding.
// A timeout counter turns a missing ack into an error response.
//
// Parameters
//   TIMEOUT  : clock edges with stb high and no ack before the cycle is aborted
//              (must be >= 1)
//
// Ports
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/req_ready                : request handshake
//   req_addr/req_wdata/req_sel/req_we  : request payload
//   rsp_valid/rsp_ready                : response handshake
//   rsp_rdata/rsp_err                  : response payload (err = timeout abort)
//   wb_addr/wb_wdata/wb_sel/wb_we      : Wishbone request outputs (registered)
//   wb_cyc/wb_stb                      : Wishbone cycle / strobe (always equal)
//   wb_rdata/wb_ack                    : Wishbone responder inputs
// -----------------------------------------------------------------------------
module wb_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WB_AW-1:0]   req_addr,
  input  logic [WB_DW-1:0]   req_wdata,
  input  logic [WB_SELW-1:0] req_sel,
  input  logic               req_we,

  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_rdata,
  output logic               rsp_err,

  output logic [WB_AW-1:0]   wb_addr,
  output logic [WB_DW-1:0]   wb_wdata,
  output logic [WB_SELW-1:0] wb_sel,
  output logic               wb_we,
  output logic               wb_cyc,
  output logic               wb_stb,
  input  logic [WB_DW-1:0]   wb_rdata,
  input  logic               wb_ack
);

  localparam int unsigned           CNT_W    = $clog2(TIMEOUT + 1);
  // Counter value at which an un-acked edge aborts the cycle.
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_init_state_e     state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [WB_DW-1:0]   rsp_rdata_q;
  logic               rsp_err_q;
  logic [WB_AW-1:0]   wb_addr_q;
  logic [WB_DW-1:0]   wb_wdata_q;
  logic [WB_SELW-1:0] wb_sel_q;
  logic               wb_we_q;
  logic               wb_cyc_q;

  // Next timeout count while waiting for ack.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Transfer FSM; every output is a register so nothing from req_* reaches
  // wb_* combinationally, and cyc/stb drop on the edge that samples ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_wdata_q  <= '0;
      wb_sel_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wb_addr_q   <= wb_word_addr(req_addr);
            wb_wdata_q  <= req_wdata;
            wb_sel_q    <= req_sel;
            wb_we_q     <= req_we;
            wb_cyc_q    <= 1'b1;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= BUS;
          end else begin
            state_q     <= IDLE;
          end
        end

        BUS: begin
          // Ack takes priority over a timeout on the same edge.
          if (wb_ack) begin
            rsp_rdata_q <= wb_we_q ? '0 : wb_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            wb_cyc_q    <= 1'b0;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            wb_cyc_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_d;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q     <= RESP;
          end
        end

        default: begin
          // Unreachable encoding: return to a safe idle bus.
          state_q     <= IDLE;
          cnt_q       <= '0;
          wb_cyc_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_addr   = wb_addr_q;
  assign wb_wdata  = wb_wdata_q;
  assign wb_sel    = wb_sel_q;
  assign wb_we     = wb_we_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_cyc_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed, table-driven bench for wb_initiator with TIMEOUT = 8.
module tb_wb_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        req_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  int n_checks = 0;
  int n_pass   = 0;

  wb_initiator #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_sel    (wb_sel),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_rdata  (wb_rdata),
    .wb_ack    (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] bus_rdata;  // wb_rdata presented with ack
    int          ack_edge;   // edge after acceptance that samples ack (0 = never)
    int          hold;       // cycles rsp_ready is held low in RESP
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_edge;   // edge after which rsp_valid first reads 1
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one request through acceptance, bus phase, response and handshake.
  // Called one time unit after a posedge; returns at the same phase.
  task automatic run_vec(input vec_t v);
    int stb_cnt;
    int resp_k;
    logic stable;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_sel   = v.sel;
    req_we    = v.we;
    req_valid = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("cyc_after_accept", {31'd0, wb_cyc}, 32'd1);
    chk("stb_after_accept", {31'd0, wb_stb}, 32'd1);
    chk("wb_addr", wb_addr, v.exp_addr);
    chk("wb_wdata", wb_wdata, v.wdata);
    chk("wb_sel", {28'd0, wb_sel}, {28'd0, v.sel});
    chk("wb_we", {31'd0, wb_we}, {31'd0, v.we});
    chk("req_ready_bus", {31'd0, req_ready}, 32'd0);

    stb_cnt = 0;
    resp_k  = 0;
    for (int k = 1; k <= 20; k++) begin
      wb_ack   = (k == v.ack_edge);
      wb_rdata = (k == v.ack_edge) ? v.bus_rdata : 32'h0BAD_0BAD;
      if (wb_stb === 1'b1) stb_cnt++;
      @(posedge clk); #1;
      wb_ack = 1'b0;
      if (rsp_valid === 1'b1) begin
        resp_k = k;
        break;
      end
    end
    chk("rsp_edge", resp_k, v.exp_edge);
    chk("stb_cycles", stb_cnt, v.exp_edge);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("cyc_dropped", {31'd0, wb_cyc}, 32'd0);
    chk("stb_dropped", {31'd0, wb_stb}, 32'd0);
    chk("req_ready_resp", {31'd0, req_ready}, 32'd0);

    // Backpressure; a stray ack on the second held edge must be ignored.
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      wb_ack   = (h == 1);
      wb_rdata = 32'h5555_5555;
      @(posedge clk); #1;
      wb_ack = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
          req_ready !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0)
        stable = 1'b0;
    end
    if (v.hold > 0) chk("hold_stable", {31'd0, stable}, 32'd1);

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_done", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          addr          wdata         sel      we    bus_rdata     ack hold exp_addr      exp_rdata     err   edge
    vecs[0] = '{32'h0000_0104, 32'h0,        4'b1111, 1'b0, 32'hDEAD_BEEF, 3, 0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[1] = '{32'h0000_0203, 32'h1234_5678, 4'b0011, 1'b1, 32'hCAFE_F00D, 3, 0, 32'h0000_0200, 32'h0,         1'b0, 3};
    vecs[2] = '{32'h1000_0008, 32'h0,        4'b1111, 1'b0, 32'h7777_7777, 0, 3, 32'h1000_0008, 32'h0,         1'b1, 8};
    vecs[3] = '{32'h0000_0040, 32'h0,        4'b1111, 1'b0, 32'hA5A5_A5A5, 8, 0, 32'h0000_0040, 32'hA5A5_A5A5, 1'b0, 8};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0,        4'b0001, 1'b0, 32'h0BAD_CAFE, 1, 5, 32'hFFFF_FFFC, 32'h0BAD_CAFE, 1'b0, 1};
    vecs[5] = '{32'h8000_0012, 32'h8765_4321, 4'b1100, 1'b1, 32'h1111_2222, 7, 2, 32'h8000_0010, 32'h0,         1'b0, 7};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_sel   = 4'h0;
    req_we    = 1'b0;
    rsp_ready = 1'b0;
    wb_rdata  = 32'h0;
    wb_ack    = 1'b0;
    #22;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_wb_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wb_addr", wb_addr, 32'h0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ack while idle must not start anything.
    wb_ack   = 1'b1;
    wb_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    chk("idle_ack_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("idle_ack_rsp", {31'd0, rsp_valid}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a bus cycle.
    req_addr  = 32'h0000_0300;
    req_we    = 1'b0;
    req_sel   = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_cyc", {31'd0, wb_cyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
